// File: rtl/bus_mux_lock.sv
// Locking master/slave mux for the 1-bit serial system bus: route latched at transaction start.
// Optional stall abort enabled by defining BUS_MUX_TIMEOUT_EN.
module bus_mux_lock #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned NUM_SLAVES     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  localparam int unsigned GW = $clog2(NUM_MASTERS + 1),
  localparam int unsigned SW = $clog2(NUM_SLAVES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [GW-1:0]          bus_grant,
  input  logic [SW-1:0]          slave_sel,
  input  logic [NUM_MASTERS-1:0] m_valid,
  input  logic [NUM_MASTERS-1:0] m_tx_address,
  input  logic [NUM_MASTERS-1:0] m_tx_data,
  input  logic [NUM_MASTERS-1:0] m_write_en,
  input  logic [NUM_MASTERS-1:0] m_read_en,
  output logic [NUM_MASTERS-1:0] m_rx_data,
  output logic [NUM_MASTERS-1:0] m_slave_ready,
  output logic [NUM_SLAVES-1:0]  s_valid,
  output logic [NUM_SLAVES-1:0]  s_rx_address,
  output logic [NUM_SLAVES-1:0]  s_rx_data,
  output logic [NUM_SLAVES-1:0]  s_write_en,
  output logic [NUM_SLAVES-1:0]  s_read_en,
  input  logic [NUM_SLAVES-1:0]  s_tx_data,
  input  logic [NUM_SLAVES-1:0]  s_slave_ready,
  output logic                   route_active,
  output logic [GW-1:0]          route_master,
  output logic [SW-1:0]          route_slave,
  output logic                   sel_error,
  output logic                   timeout
);

  typedef enum logic [1:0] {StIdle, StActive, StRelease} state_e;

  localparam logic [GW-1:0] MaxGrant = GW'(NUM_MASTERS);
  localparam logic [SW-1:0] MaxSel   = SW'(NUM_SLAVES);

  state_e        state_q, state_d;
  logic [GW-1:0] master_q, master_d;
  logic [SW-1:0] slave_q, slave_d;
  logic          seen_valid_q, seen_valid_d;
  logic          sel_error_q, sel_error_d;
  logic          timeout_q, timeout_d;

  logic grant_ok, sel_ok, active;
  logic lm_valid, lm_addr, lm_data, lm_we, lm_re;
  logic ls_tx, ls_ready;
  logic stall_abort;

  // Grant values above NUM_MASTERS count as no grant.
  assign grant_ok = (bus_grant != '0) && (bus_grant <= MaxGrant);
  assign sel_ok   = (slave_sel != '0) && (slave_sel <= MaxSel);
  assign active   = (state_q == StActive);

  always_comb begin
    lm_valid = 1'b0;
    lm_addr  = 1'b0;
    lm_data  = 1'b0;
    lm_we    = 1'b0;
    lm_re    = 1'b0;
    ls_tx    = 1'b0;
    ls_ready = 1'b0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (master_q == GW'(i + 1)) begin
        lm_valid = m_valid[i];
        lm_addr  = m_tx_address[i];
        lm_data  = m_tx_data[i];
        lm_we    = m_write_en[i];
        lm_re    = m_read_en[i];
      end
    end
    for (int unsigned j = 0; j < NUM_SLAVES; j++) begin
      if (slave_q == SW'(j + 1)) begin
        ls_tx    = s_tx_data[j];
        ls_ready = s_slave_ready[j];
      end
    end
  end

`ifdef BUS_MUX_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = '0;
    stall_abort = 1'b0;
    if (active && !ls_ready) begin
      stall_cnt_d = lm_valid ? stall_cnt_q + 1'b1 : stall_cnt_q;
      stall_abort = (stall_cnt_d == CW'(TIMEOUT_CYCLES));
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state_d != StActive) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign stall_abort        = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    master_d     = master_q;
    slave_d      = slave_q;
    seen_valid_d = seen_valid_q;
    sel_error_d  = 1'b0;
    timeout_d    = 1'b0;
    case (state_q)
      StIdle: begin
        seen_valid_d = 1'b0;
        if (grant_ok) begin
          if (sel_ok) begin
            state_d  = StActive;
            master_d = bus_grant;
            slave_d  = slave_sel;
          end else begin
            sel_error_d = 1'b1;
          end
        end
      end
      StActive: begin
        if (lm_valid) seen_valid_d = 1'b1;
        if (stall_abort) begin
          state_d   = StRelease;
          timeout_d = 1'b1;
        end else if (!lm_valid && (seen_valid_q || !grant_ok)) begin
          state_d = StRelease;
        end
      end
      StRelease: begin
        state_d      = StIdle;
        seen_valid_d = 1'b0;
        master_d     = '0;
        slave_d      = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      master_q     <= '0;
      slave_q      <= '0;
      seen_valid_q <= 1'b0;
      sel_error_q  <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      master_q     <= master_d;
      slave_q      <= slave_d;
      seen_valid_q <= seen_valid_d;
      sel_error_q  <= sel_error_d;
      timeout_q    <= timeout_d;
    end
  end

  // Forward and return paths are combinational from the latched route.
  always_comb begin
    s_valid       = '0;
    s_rx_address  = '0;
    s_rx_data     = '0;
    s_write_en    = '0;
    s_read_en     = '0;
    m_rx_data     = '0;
    m_slave_ready = '0;
    for (int unsigned j = 0; j < NUM_SLAVES; j++) begin
      if (active && slave_q == SW'(j + 1)) begin
        s_valid[j]      = lm_valid;
        s_rx_address[j] = lm_addr;
        s_rx_data[j]    = lm_data;
        s_write_en[j]   = lm_we;
        s_read_en[j]    = lm_re;
      end
    end
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (active && master_q == GW'(i + 1)) begin
        m_rx_data[i]     = ls_tx;
        m_slave_ready[i] = ls_ready;
      end
    end
  end

  assign route_active = active;
  assign route_master = active ? master_q : '0;
  assign route_slave  = active ? slave_q : '0;
  assign sel_error    = sel_error_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_bus_mux_lock.sv
// Scoreboard bench for bus_mux_lock: directed cycles push expected outputs, a negedge monitor compares.
module tb_bus_mux_lock;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0] bus_grant;
  logic [1:0] slave_sel;
  logic       alt_sel;
  logic [2:0] sel4;
  logic [1:0] m_valid, m_tx_address, m_tx_data, m_write_en, m_read_en;
  logic [1:0] m_rx_data, m_slave_ready;
  logic [2:0] s_valid, s_rx_address, s_rx_data, s_write_en, s_read_en;
  logic [2:0] s_tx_data, s_slave_ready;
  logic       route_active, sel_error, timeout;
  logic [1:0] route_master, route_slave;

  logic [1:0] d4_m_rx_data, d4_m_slave_ready, d4_route_master;
  logic [3:0] d4_s_valid, d4_s_rx_address, d4_s_rx_data, d4_s_write_en, d4_s_read_en;
  logic [2:0] d4_route_slave;
  logic       d4_route_active, d4_sel_error, d4_timeout;

  // Second instance has SW=3 so an out-of-range select (5) can be driven.
  assign sel4 = alt_sel ? 3'd5 : {1'b0, slave_sel};

  bus_mux_lock #(.NUM_MASTERS(2), .NUM_SLAVES(3), .TIMEOUT_CYCLES(4)) u_dut (
    .clk(clk), .rst(rst), .bus_grant(bus_grant), .slave_sel(slave_sel),
    .m_valid(m_valid), .m_tx_address(m_tx_address), .m_tx_data(m_tx_data),
    .m_write_en(m_write_en), .m_read_en(m_read_en),
    .m_rx_data(m_rx_data), .m_slave_ready(m_slave_ready),
    .s_valid(s_valid), .s_rx_address(s_rx_address), .s_rx_data(s_rx_data),
    .s_write_en(s_write_en), .s_read_en(s_read_en),
    .s_tx_data(s_tx_data), .s_slave_ready(s_slave_ready),
    .route_active(route_active), .route_master(route_master), .route_slave(route_slave),
    .sel_error(sel_error), .timeout(timeout)
  );

  bus_mux_lock #(.NUM_MASTERS(2), .NUM_SLAVES(4), .TIMEOUT_CYCLES(4)) u_dut4 (
    .clk(clk), .rst(rst), .bus_grant(bus_grant), .slave_sel(sel4),
    .m_valid(m_valid), .m_tx_address(m_tx_address), .m_tx_data(m_tx_data),
    .m_write_en(m_write_en), .m_read_en(m_read_en),
    .m_rx_data(d4_m_rx_data), .m_slave_ready(d4_m_slave_ready),
    .s_valid(d4_s_valid), .s_rx_address(d4_s_rx_address), .s_rx_data(d4_s_rx_data),
    .s_write_en(d4_s_write_en), .s_read_en(d4_s_read_en),
    .s_tx_data({1'b0, s_tx_data}), .s_slave_ready({1'b0, s_slave_ready}),
    .route_active(d4_route_active), .route_master(d4_route_master),
    .route_slave(d4_route_slave), .sel_error(d4_sel_error), .timeout(d4_timeout)
  );

  typedef struct packed {
    logic       ra;
    logic [1:0] rm;
    logic [1:0] rs;
    logic       se;
    logic       to;
    logic [2:0] sv, sa, sd, sw, sr;
    logic [1:0] mrx, mrdy;
  } obs_t;

  typedef struct {
    obs_t       v;
    logic [1:0] v4;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  obs_t mon_act;
  int   n_checks = 0;
  int   n_fail   = 0;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e   = exp_q.pop_front();
      mon_act = {route_active, route_master, route_slave, sel_error, timeout, s_valid,
                 s_rx_address, s_rx_data, s_write_en, s_read_en, m_rx_data, m_slave_ready};
      n_checks++;
      if (mon_act !== mon_e.v) begin
        n_fail++;
        $display("FAIL %s: outputs got %h expected %h", mon_e.name, mon_act, mon_e.v);
      end
      n_checks++;
      if ({d4_route_active, d4_sel_error} !== mon_e.v4) begin
        n_fail++;
        $display("FAIL %s_sw3: {active,sel_error} got %b expected %b", mon_e.name,
                 {d4_route_active, d4_sel_error}, mon_e.v4);
      end
    end
  end

  task automatic step(input string name, input logic ra, input logic [1:0] rm,
                      input logic [1:0] rs, input logic se, input logic to,
                      input logic [2:0] sv, input logic [2:0] sa, input logic [2:0] sd,
                      input logic [2:0] sw, input logic [2:0] sr,
                      input logic [1:0] mrx, input logic [1:0] mrdy);
    exp_t e;
    e.v    = {ra, rm, rs, se, to, sv, sa, sd, sw, sr, mrx, mrdy};
    e.v4   = {ra, se};
    e.name = name;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic step_zero(input string name, input logic se = 1'b0, input logic to = 1'b0);
    step(name, 1'b0, 2'd0, 2'd0, se, to, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'b00, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus_grant     = 2'd0;
    slave_sel     = 2'd0;
    alt_sel       = 1'b0;
    m_valid       = 2'b00;
    m_tx_address  = 2'b01;
    m_tx_data     = 2'b10;
    m_write_en    = 2'b01;
    m_read_en     = 2'b10;
    s_tx_data     = 3'b100;
    s_slave_ready = 3'b110;
    repeat (2) @(posedge clk);
    #1;
    step_zero("reset_state");
    rst = 1'b0; bus_grant = 2'd1; slave_sel = 2'd3;
    step_zero("idle_before_lock");
    m_valid = 2'b01;
    step("lock_1_3", 1, 2'd1, 2'd3, 0, 0, 3'b100, 3'b100, 3'b000, 3'b100, 3'b000, 2'b01, 2'b01);
    bus_grant = 2'd2; slave_sel = 2'd1; m_valid = 2'b11; s_tx_data = 3'b000;
    step("locked_ignores_sel", 1, 2'd1, 2'd3, 0, 0, 3'b100, 3'b100, 3'b000, 3'b100, 3'b000,
         2'b00, 2'b01);
    m_valid = 2'b10;
    step("valid_drop", 1, 2'd1, 2'd3, 0, 0, 3'b000, 3'b100, 3'b000, 3'b100, 3'b000,
         2'b00, 2'b01);
    step_zero("release_turnaround");
    step_zero("idle_gap");
    s_tx_data = 3'b001;
    step("lock_2_1", 1, 2'd2, 2'd1, 0, 0, 3'b001, 3'b000, 3'b001, 3'b000, 3'b001, 2'b10, 2'b00);
    m_valid = 2'b00; bus_grant = 2'd0; slave_sel = 2'd0;
    step("end_2_1", 1, 2'd2, 2'd1, 0, 0, 3'b000, 3'b000, 3'b001, 3'b000, 3'b001, 2'b10, 2'b00);
    bus_grant = 2'd2;
    step_zero("release_ignores_grant");
    step_zero("idle_bad_sel_0");
    bus_grant = 2'd0;
    step_zero("sel_error_pulse_0", 1'b1);
    bus_grant = 2'd2; alt_sel = 1'b1;
    step_zero("idle_bad_sel_5");
    bus_grant = 2'd3; slave_sel = 2'd1; alt_sel = 1'b0;
    step_zero("sel_error_pulse_5", 1'b1);
    step_zero("grant_out_of_range");
    bus_grant = 2'd1; slave_sel = 2'd2;
    step_zero("idle_lock_1_2");
    step("lock_1_2_no_valid", 1, 2'd1, 2'd2, 0, 0, 3'b000, 3'b010, 3'b000, 3'b010, 3'b000,
         2'b00, 2'b01);
    bus_grant = 2'd0;
    step("grant_withdrawn", 1, 2'd1, 2'd2, 0, 0, 3'b000, 3'b010, 3'b000, 3'b010, 3'b000,
         2'b00, 2'b01);
    bus_grant = 2'd1; slave_sel = 2'd3;
    step_zero("release_after_withdraw");
    step_zero("idle_relock");
    m_valid = 2'b01; rst = 1'b1;
    step("active_during_rst", 1, 2'd1, 2'd3, 0, 0, 3'b100, 3'b100, 3'b000, 3'b100, 3'b000,
         2'b00, 2'b01);
    rst = 1'b0;
    step_zero("idle_after_rst");
    step("relock_after_rst", 1, 2'd1, 2'd3, 0, 0, 3'b100, 3'b100, 3'b000, 3'b100, 3'b000,
         2'b00, 2'b01);
    s_slave_ready = 3'b000;
`ifdef BUS_MUX_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      step("stall", 1, 2'd1, 2'd3, 0, 0, 3'b100, 3'b100, 3'b000, 3'b100, 3'b000, 2'b00, 2'b00);
    end
    step_zero("timeout_release", 1'b0, 1'b1);
    step_zero("idle_after_timeout");
    step("relock_after_timeout", 1, 2'd1, 2'd3, 0, 0, 3'b100, 3'b100, 3'b000, 3'b100, 3'b000,
         2'b00, 2'b00);
`else
    for (int i = 0; i < 8; i++) begin
      step("stall_hold", 1, 2'd1, 2'd3, 0, 0, 3'b100, 3'b100, 3'b000, 3'b100, 3'b000,
           2'b00, 2'b00);
    end
`endif
    repeat (2) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_mux_lock.md
Name: bus_mux_lock

Overview:
- Parametrised next-generation bus interconnect mux for the 1-bit serial system bus.
- Routes one of NUM_MASTERS masters to one of NUM_SLAVES slaves, single clock domain.
- Unlike the fixed 2x3 mux, the master/slave route is latched at transaction start and held until the transaction ends.
- Adds invalid-select error signalling, a bus turnaround cycle and route status outputs; sits between the arbiter/address decoder and the slaves.

Parameters:
- NUM_MASTERS, 2, number of master ports (1..7)
- NUM_SLAVES, 3, number of slave ports (1..7)
- TIMEOUT_CYCLES, 64, stall limit used only when BUS_MUX_TIMEOUT_EN is defined (>=2)
- Derived, not overridable: GW = $clog2(NUM_MASTERS+1); SW = $clog2(NUM_SLAVES+1)

Ports:
- clk  in  1  bus clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- bus_grant  in  GW  granted master, 1..NUM_MASTERS; 0 = none
- slave_sel  in  SW  target slave, 1..NUM_SLAVES; 0 or >NUM_SLAVES invalid
- m_valid, m_tx_address, m_tx_data, m_write_en, m_read_en  in  NUM_MASTERS each  per-master bit i = master i+1
- m_rx_data, m_slave_ready  out  NUM_MASTERS each  return path to masters
- s_valid, s_rx_address, s_rx_data, s_write_en, s_read_en  out  NUM_SLAVES each  forward path to slaves
- s_tx_data, s_slave_ready  in  NUM_SLAVES each  slave return path
- route_active  out  1  high in ACTIVE
- route_master  out  GW  latched master, 0 when not ACTIVE
- route_slave  out  SW  latched slave, 0 when not ACTIVE
- sel_error  out  1  one-cycle pulse on invalid slave_sel with valid grant
- timeout  out  1  one-cycle pulse on stall abort

Behaviour:
- Reset: state IDLE; all outputs 0; internal seen_valid and stall counter cleared. Reset overrides any cycle, including mid-transaction.
- FSM states: IDLE, ACTIVE, RELEASE.
- IDLE:
  - All s_* and m_* outputs are 0.
  - If bus_grant is in 1..NUM_MASTERS and slave_sel is in 1..NUM_SLAVES, latch both and go to ACTIVE next cycle. Lock latency is 1 cycle.
  - If bus_grant is valid but slave_sel is invalid, pulse sel_error for 1 cycle and stay IDLE.
  - If bus_grant is 0 or >NUM_MASTERS, do nothing.
- ACTIVE:
  - Forward path: the locked master's valid/address/data/write_en/read_en drive only the locked slave's bits, combinationally (zero added latency). All other s_* bits are 0.
  - Return path: the locked slave's tx_data and slave_ready drive only the locked master's m_rx_data and m_slave_ready bits. Other masters see 0.
  - Changes on bus_grant or slave_sel are ignored while locked.
  - seen_valid is set on any cycle where the locked master's valid is 1.
  - Exit to RELEASE on the first edge where the locked master's valid is 0 and either seen_valid=1 (transaction ended) or bus_grant=0 (grant withdrawn before start).
- RELEASE:
  - One turnaround cycle: all outputs 0, seen_valid cleared, no lock possible.
  - Next state is IDLE. A new lock needs >=1 IDLE cycle, so the minimum gap between routes is 2 cycles.
- Simultaneous events:
  - A valid grant present on the same edge the FSM enters IDLE is acted on in that IDLE cycle.
  - An invalid slave_sel in ACTIVE raises no sel_error.
- Grant values above NUM_MASTERS are treated as 0.

Optional Feature:
- Macro: BUS_MUX_TIMEOUT_EN.
- Defined:
  - In ACTIVE, a stall counter increments on each cycle where the locked master's valid=1 and the locked slave's slave_ready=0.
  - The counter clears on any cycle where slave_ready=1 and on leaving ACTIVE.
  - When the count reaches TIMEOUT_CYCLES, timeout pulses 1 cycle and the FSM goes to RELEASE regardless of valid.
- Undefined: no counter is built; timeout is tied 0; exit is by the valid/grant rules only.

Test Plan:
- NUM_MASTERS=2, NUM_SLAVES=3; bus_grant=1, slave_sel=3 -> route_active=1 one cycle later, route_master=1, route_slave=3; s_valid=3'b100, m_rx_data[0] follows s_tx_data[2]; all other s_* bits 0.
- Locked 1->3; change slave_sel to 1 and bus_grant to 2 mid-transfer -> route unchanged. Drop m_valid[0] -> RELEASE one cycle with all outputs 0, then lock 2->1 on the following cycle.
- bus_grant=2, slave_sel=0 -> sel_error high exactly 1 cycle, route_active stays 0. Repeat with slave_sel=5 on SW=3 -> same result.
- Locked and m_valid never asserted; set bus_grant=0 -> RELEASE on the next edge, then IDLE.
- Assert rst for 1 cycle mid-ACTIVE -> next cycle all outputs 0 and state IDLE; a held valid grant re-locks 1 cycle after rst falls.
- With BUS_MUX_TIMEOUT_EN, TIMEOUT_CYCLES=4: valid=1, slave_ready=0 held -> timeout pulses after 4 stall cycles, then RELEASE. Without the macro, the same stimulus holds ACTIVE indefinitely and timeout stays 0.
